mul_arb_2ch: RTL and testbench

MUL_ARB_2CH -- requirements
Module: mul_arb_2ch

---
 rtl/mul_arb_pkg.sv | 28 ++
 rtl/array_multiplier_4x4.sv | 24 ++
 rtl/mul_arb_2ch.sv | 123 ++++++++++++
 tb/tb_mul_arb_2ch.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_arb_pkg.sv
// rtl/mul_arb_pkg.sv - shared types and widths for the two-channel multiplier arbiter
package mul_arb_pkg;

    localparam int OPW = 4;
    localparam int PW  = 8;
    localparam int NCH = 2;
    localparam int CW  = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Ripple-carry sum built from gate-level full adders; the multiplier
    // array uses this instead of a behavioural adder.
    function automatic logic [PW-1:0] ripple_add(input logic [PW-1:0] x, input logic [PW-1:0] y);
        logic [PW-1:0] s;
        logic          c;
        c = 1'b0;
        for (int i = 0; i < PW; i++) begin
            s[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (x[i] & c) | (y[i] & c);
        end
        return s;
    endfunction

endpackage

// File: rtl/array_multiplier_4x4.sv
// rtl/array_multiplier_4x4.sv - combinational 4x4 unsigned array multiplier
module array_multiplier_4x4
    import mul_arb_pkg::*;
(
    input  logic [OPW-1:0] a,
    input  logic [OPW-1:0] b,
    output logic [PW-1:0]  p
);

    logic [PW-1:0] row [OPW];
    logic [PW-1:0] acc [OPW+1];

    // Each row is a shifted AND partial product; rows are summed in a chain.
    always_comb begin
        acc[0] = '0;
        for (int i = 0; i < OPW; i++) begin
            row[i]     = {{(PW-OPW){1'b0}}, a & {OPW{b[i]}}} << i;
            acc[i + 1] = ripple_add(acc[i], row[i]);
        end
    end

    assign p = acc[OPW];

endmodule

// File: rtl/mul_arb_2ch.sv
// rtl/mul_arb_2ch.sv - round-robin arbiter sharing one multiplier between two requesters
module mul_arb_2ch
    import mul_arb_pkg::*;
#(
    parameter int MUL_LAT = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [OPW-1:0] req0_a,
    input  logic [OPW-1:0] req0_b,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [OPW-1:0] req1_a,
    input  logic [OPW-1:0] req1_b,
    output logic           rsp0_valid,
    input  logic           rsp0_ready,
    output logic           rsp1_valid,
    input  logic           rsp1_ready,
    output logic [PW-1:0]  rsp_p,
    output logic           busy,
    output logic           grant_id
);

    localparam logic [CW-1:0] CNT_LOAD = CW'(MUL_LAT - 1);

    state_t         state_q;
    state_t         state_d;
    logic [CW-1:0]  cnt_q;
    logic [OPW-1:0] op_a_q;
    logic [OPW-1:0] op_b_q;
    logic [PW-1:0]  result_q;
    logic [PW-1:0]  mul_p;
    logic           last_grant_q;
    logic           grant_q;

    logic           sel_ch;
    logic           accept;
    logic           load_result;
    logic           rsp_taken;

    array_multiplier_4x4 u_mul (
        .a (op_a_q),
        .b (op_b_q),
        .p (mul_p)
    );

    // A lone requester wins outright; the pointer only breaks ties.
    always_comb begin
        sel_ch = 1'b0;
        if (req0_valid && req1_valid) begin
            sel_ch = ~last_grant_q;
        end else begin
            sel_ch = req1_valid;
        end
    end

    assign rsp_taken = grant_q ? rsp1_ready : rsp0_ready;

    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        load_result = 1'b0;
        case (state_q)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    accept  = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (cnt_q == '0) begin
                    load_result = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_taken) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            result_q     <= '0;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_a_q       <= sel_ch ? req1_a : req0_a;
                op_b_q       <= sel_ch ? req1_b : req0_b;
                cnt_q        <= CNT_LOAD;
                grant_q      <= sel_ch;
                last_grant_q <= sel_ch;
            end else if (state_q == CALC && cnt_q != '0) begin
                cnt_q <= cnt_q - CW'(1);
            end
            if (load_result) begin
                result_q <= mul_p;
            end
        end
    end

    assign req0_ready = accept && !sel_ch;
    assign req1_ready = accept && sel_ch;
    assign rsp0_valid = (state_q == RESP) && !grant_q;
    assign rsp1_valid = (state_q == RESP) && grant_q;
    assign rsp_p      = result_q;
    assign busy       = (state_q != IDLE);
    assign grant_id   = busy ? grant_q : 1'b0;

endmodule

// File: tb/tb_mul_arb_2ch.sv
// tb/tb_mul_arb_2ch.sv - directed and table-driven checks for mul_arb_2ch
module tb_mul_arb_2ch;

    logic       clk;
    logic       rst;
    logic       req0_valid, req1_valid;
    logic [3:0] req0_a, req0_b, req1_a, req1_b;
    logic       rsp0_ready, rsp1_ready;

    logic       req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy, grant_id;
    logic [7:0] rsp_p;
    logic       d4_req0_ready, d4_req1_ready, d4_rsp0_valid, d4_rsp1_valid, d4_busy, d4_grant_id;
    logic [7:0] d4_rsp_p;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       v0;
        logic       v1;
        logic [3:0] a0;
        logic [3:0] b0;
        logic [3:0] a1;
        logic [3:0] b1;
        logic       exp_ch;
        logic [7:0] exp_p;
    } vec_t;

    vec_t vecs[8];

    mul_arb_2ch #(.MUL_LAT(1)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_p(rsp_p), .busy(busy), .grant_id(grant_id)
    );

    mul_arb_2ch #(.MUL_LAT(4)) dut4 (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(d4_req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(d4_req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(d4_rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(d4_rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_p(d4_rsp_p), .busy(d4_busy), .grant_id(d4_grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic serve_vec(input vec_t v, input int idx);
        step();
        req0_valid = v.v0; req0_a = v.a0; req0_b = v.b0;
        req1_valid = v.v1; req1_a = v.a1; req1_b = v.b1;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        #1;
        chk($sformatf("vec%0d_req0_ready", idx), req0_ready, !v.exp_ch);
        chk($sformatf("vec%0d_req1_ready", idx), req1_ready, v.exp_ch);
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = 4'hF; req0_b = 4'hE; req1_a = 4'hD; req1_b = 4'hC;
        #1;
        chk($sformatf("vec%0d_grant_id", idx), grant_id, v.exp_ch);
        chk($sformatf("vec%0d_early_rsp", idx), {rsp1_valid, rsp0_valid}, 0);
        step();
        #1;
        chk($sformatf("vec%0d_rsp_valid", idx), {rsp1_valid, rsp0_valid}, v.exp_ch ? 2 : 1);
        chk($sformatf("vec%0d_rsp_p", idx), rsp_p, v.exp_p);
        step();
        #1;
        chk($sformatf("vec%0d_idle", idx), busy, 0);
    endtask

    function automatic logic rv(input logic ch);
        return ch ? rsp1_valid : rsp0_valid;
    endfunction

    function automatic logic qr(input logic ch);
        return ch ? req1_ready : req0_ready;
    endfunction

    initial begin
        logic       ch;
        logic [3:0] ea, eb;
        logic [7:0] got_p;
        int         seen, n;
        logic       done;

        //            v0    v1    a0     b0     a1     b1    ch    p
        vecs[0] = '{1'b1, 1'b1, 4'd7,  4'd9,  4'd15, 4'd15, 1'b0, 8'd63};
        vecs[1] = '{1'b1, 1'b1, 4'd7,  4'd9,  4'd15, 4'd15, 1'b1, 8'd225};
        vecs[2] = '{1'b1, 1'b0, 4'd3,  4'd5,  4'd0,  4'd0,  1'b0, 8'd15};
        vecs[3] = '{1'b1, 1'b0, 4'd15, 4'd15, 4'd9,  4'd9,  1'b0, 8'd225};
        vecs[4] = '{1'b1, 1'b1, 4'd2,  4'd8,  4'd4,  4'd4,  1'b1, 8'd16};
        vecs[5] = '{1'b0, 1'b1, 4'd6,  4'd6,  4'd0,  4'd13, 1'b1, 8'd0};
        vecs[6] = '{1'b1, 1'b1, 4'd1,  4'd1,  4'd12, 4'd11, 1'b0, 8'd1};
        vecs[7] = '{1'b0, 1'b1, 4'd0,  4'd0,  4'd10, 4'd10, 1'b1, 8'd100};

        rst = 1'b1;
        req0_valid = 0; req1_valid = 0;
        req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
        rsp0_ready = 0; rsp1_ready = 0;
        do_reset();
        #1;
        chk("rst_outputs", {req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy, grant_id}, 0);
        chk("rst_rsp_p", rsp_p, 0);
        chk("rst_d4_outputs", {d4_req0_ready, d4_req1_ready, d4_rsp0_valid, d4_rsp1_valid, d4_busy, d4_grant_id, d4_rsp_p}, 0);

        // Contention straight after reset: channel 0 first, then channel 1.
        step();
        req0_valid = 1; req0_a = 7; req0_b = 9;
        req1_valid = 1; req1_a = 15; req1_b = 15;
        rsp0_ready = 1; rsp1_ready = 1;
        #1;
        chk("cont_ready", {req1_ready, req0_ready}, 1);
        step(); #1;
        chk("cont_calc_ready", {req1_ready, req0_ready}, 0);
        chk("cont_grant0", {busy, grant_id}, 2);
        step(); #1;
        chk("cont_rsp0", {rsp1_valid, rsp0_valid}, 1);
        chk("cont_p0", rsp_p, 63);
        step(); #1;
        chk("cont_ready1", {req1_ready, req0_ready, busy}, 4);
        step();
        req0_valid = 0; req1_valid = 0;
        #1;
        chk("cont_grant1", grant_id, 1);
        step(); #1;
        chk("cont_rsp1", {rsp1_valid, rsp0_valid}, 2);
        chk("cont_p1", rsp_p, 225);
        step(); #1;
        chk("cont_idle", busy, 0);

        for (int i = 0; i < 8; i++) begin
            serve_vec(vecs[i], i);
        end

        // Backpressure on channel 1 while channel 0 waits.
        step();
        req1_valid = 1; req1_a = 15; req1_b = 15;
        rsp0_ready = 1; rsp1_ready = 0;
        #1;
        chk("bp_accept1", {req1_ready, req0_ready}, 2);
        step();
        req1_valid = 0;
        req0_valid = 1; req0_a = 3; req0_b = 3;
        #1;
        chk("bp_calc_ready0", req0_ready, 0);
        for (int k = 0; k < 5; k++) begin
            step(); #1;
            chk($sformatf("bp_hold%0d", k), {rsp1_valid, rsp0_valid, busy, req0_ready}, 4'b1010);
            chk($sformatf("bp_hold%0d_p", k), rsp_p, 225);
        end
        step();
        rsp1_ready = 1;
        #1;
        chk("bp_release", {rsp1_valid, rsp_p}, {1'b1, 8'd225});
        step(); #1;
        chk("bp_next_accept", {req0_ready, busy, rsp1_valid}, 3'b100);
        step();
        req0_valid = 0;
        #1;
        chk("bp_grant0", {busy, grant_id}, 2);
        step(); #1;
        chk("bp_rsp0", {rsp1_valid, rsp0_valid, rsp_p}, {2'b01, 8'd9});
        step(); #1;
        chk("bp_idle", busy, 0);

        // Reset two cycles into a MUL_LAT=4 transaction.
        do_reset();
        rsp0_ready = 1; rsp1_ready = 1;
        req0_valid = 1; req0_a = 5; req0_b = 6;
        #1;
        chk("d4_accept0", d4_req0_ready, 1);
        step();
        req0_valid = 0;
        step();
        rst = 1;
        #1;
        chk("d4_busy_before_rst", d4_busy, 1);
        step();
        rst = 0;
        #1;
        chk("d4_after_rst", {d4_req0_ready, d4_req1_ready, d4_rsp0_valid, d4_rsp1_valid, d4_busy, d4_grant_id, d4_rsp_p}, 0);
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            step(); #1;
            if (d4_rsp0_valid || d4_rsp1_valid) seen++;
        end
        chk("d4_no_rsp_after_rst", seen, 0);
        req1_valid = 1; req1_a = 4; req1_b = 3;
        #1;
        chk("d4_accept1", {d4_req1_ready, d4_req0_ready}, 2);
        step();
        req1_valid = 0;
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            #1;
            if (d4_rsp0_valid || d4_rsp1_valid) seen++;
            step();
        end
        #1;
        chk("d4_latency_early", seen, 0);
        chk("d4_rsp1", {d4_rsp1_valid, d4_rsp0_valid, d4_rsp_p}, {2'b10, 8'd12});

        // All operand pairs, alternating channels, random gaps and ready stalls.
        do_reset();
        rsp0_ready = 0; rsp1_ready = 0;
        for (int i = 0; i < 256; i++) begin
            ch = i[0];
            ea = i[7:4];
            eb = i[3:0];
            repeat ($urandom_range(0, 2)) step();
            step();
            if (ch) begin
                req1_valid = 1; req1_a = ea; req1_b = eb;
            end else begin
                req0_valid = 1; req0_a = ea; req0_b = eb;
            end
            #1;
            n = 0;
            while (!qr(ch) && n < 8) begin
                step(); #1;
                n++;
            end
            if (n >= 8) chk($sformatf("exh%0d_accept_timeout", i), 0, 1);
            step();
            req0_valid = 0; req1_valid = 0;
            req0_a = 4'($urandom); req0_b = 4'($urandom);
            req1_a = 4'($urandom); req1_b = 4'($urandom);
            done = 0;
            n = 0;
            got_p = 0;
            while (!done && n < 40) begin
                rsp0_ready = 1'($urandom_range(0, 1));
                rsp1_ready = 1'($urandom_range(0, 1));
                #1;
                if (rv(ch) && (ch ? rsp1_ready : rsp0_ready)) begin
                    got_p = rsp_p;
                    done  = 1;
                    if (rv(!ch)) chk($sformatf("exh%0d_wrong_ch", i), 1, 0);
                end else begin
                    step();
                    n++;
                end
            end
            chk($sformatf("exh%0d_p", i), {done, got_p}, {1'b1, 8'(ea * eb)});
            step();
            rsp0_ready = 0; rsp1_ready = 0;
            #1;
            chk($sformatf("exh%0d_dup", i), {rsp1_valid, rsp0_valid, busy}, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=1 expected=0");
        $fatal(1, "timeout");
    end

endmodule
